m_mem_access: RTL and testbench
===============================

M_MEM_ACCESS -- requirements
Module: m_mem_access

Interface
REQ-001 The module SHALL have the following ports, one per line: name  direction  width  meaning.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 lsOp_M  in  4  M-stage op: 0000 none, 0001 lw, 0010 lh, 0011 lhu, 0100 lb, 0101 lbu, 0110 sw, 0111 sh, 1000 sb; others treated as none.
REQ-005 addr_M  in  32  effective byte address.
REQ-006 wdata_M  in  32  store data (from rt).
REQ-007 flush  in  1  exception/eret flush of the M-stage instruction.
REQ-008 stall_M  out  1  freezes the pipeline at and before M.
REQ-009 exc_AdEL / exc_AdES  out  1 each  misaligned load / store.
REQ-010 m_addr  out  32  word address {addr_M[31:2],2'b00}.
REQ-011 m_wdata  out  32  lane-replicated store data; m_byteen  out  4  byte strobes.
REQ-012 m_req  out  1  bus request; m_wr  out  1  1 means write; m_ack  in  1  bus completion; m_rdata  in  32  read word.
REQ-013 dataOut  out  32, lsOpOut  out  4, addrLow2Out  out  2  feed the load-extension stage; done  out  1  one-cycle completion pulse.

Function
REQ-014 Valid access: lsOp_M in {0001..1000}, aligned, and flush==0.
REQ-015 Alignment rule: lw/sw need addr_M[1:0]==00; lh/lhu/sh need addr_M[0]==0; byte ops are always aligned.
REQ-016 Misalignment: exc_AdEL (load) or exc_AdES (store) SHALL assert combinationally in IDLE; no bus request; stall_M=0.
REQ-017 FSM states: IDLE, WAIT, DONE.
REQ-018 IDLE -> WAIT on a valid access; at that edge, register m_req=1, m_wr, m_addr, m_byteen, m_wdata, lsOpOut and addrLow2Out.
REQ-019 WAIT: hold all bus outputs stable until m_ack=1; on ack, capture m_rdata into dataOut for loads (unchanged for stores), clear m_req, go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; lsOp_M is ignored in DONE.
REQ-021 stall_M = (IDLE and valid access) or WAIT; stall_M=0 in DONE, so the instruction retires.
REQ-022 Minimum latency is 3 cycles in M (detect, WAIT with same-cycle ack, DONE); each wait cycle without ack adds one.
REQ-023 Byte strobes: sw 1111; sh 0011 if addr[1]==0, else 1100; sb 0001 shifted left by addr[1:0]; loads 1111.
REQ-024 Write data: sw wdata_M; sh {2{wdata_M[15:0]}}; sb {4{wdata_M[7:0]}}; loads 0.
REQ-025 Flush in IDLE suppresses launch; in WAIT it is latched as kill and the access runs to ack (not cancellable).
REQ-026 When killed, DONE SHALL keep done=0 and leave dataOut unchanged; kill clears on return to IDLE.
REQ-027 m_ack outside WAIT SHALL be ignored.

Reset
REQ-028 On reset_n=0, immediately: state IDLE; m_req, m_wr, m_byteen, m_addr, m_wdata, dataOut, lsOpOut, addrLow2Out, done and kill all zero.
REQ-029 Reset mid-WAIT SHALL drop m_req at once; a late m_ack after release is ignored.

Structure
REQ-030 The lsOp encodings and FSM state encodings SHALL live in a shared definitions package/header, also used by the load-extension stage.
REQ-031 Strobe and write-data lane logic SHALL be one combinational sub-module, m_store_align.

Verification
REQ-032 lw addr 0x100, ack in first WAIT cycle, m_rdata 0xDEADBEEF -> stall_M high 2 cycles, done in cycle 3, dataOut 0xDEADBEEF, addrLow2Out 00.
REQ-033 sb addr 0x203, wdata 0x000000A5, ack after 3 wait cycles -> m_byteen 1000, m_wdata 0xA5A5A5A5, m_addr 0x200, stall_M high 5 cycles.
REQ-034 lh addr 0x101 -> exc_AdEL=1, m_req never rises, stall_M=0; sw addr 0x102 -> exc_AdES=1.
REQ-035 lbu addr 0x302, flush pulsed in WAIT, ack 2 cycles later with m_rdata 0x11223344 -> done stays 0, dataOut unchanged.
REQ-036 reset_n low mid-WAIT -> m_req=0 same cycle; after release, a late m_ack leaves state IDLE and done=0.

Source files
------------

// File: rtl/m_mem_access_pkg.sv
// Shared definitions for the M-stage memory access block and the load-extension
// stage: load/store opcode encodings, FSM state encoding and small decode helpers.
package m_mem_access_pkg;

    typedef enum logic [3:0] {
        LS_NONE = 4'b0000,
        LS_LW   = 4'b0001,
        LS_LH   = 4'b0010,
        LS_LHU  = 4'b0011,
        LS_LB   = 4'b0100,
        LS_LBU  = 4'b0101,
        LS_SW   = 4'b0110,
        LS_SH   = 4'b0111,
        LS_SB   = 4'b1000
    } ls_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= LS_LW) && (op <= LS_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= LS_SW) && (op <= LS_SB);
    endfunction

    // Word ops need a word boundary, halfword ops a halfword boundary;
    // byte ops (and non-memory codes) are never misaligned.
    function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] low2);
        logic ok;
        ok = 1'b1;
        if (op == LS_LW || op == LS_SW) begin
            ok = (low2 == 2'b00);
        end else if (op == LS_LH || op == LS_LHU || op == LS_SH) begin
            ok = (low2[0] == 1'b0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/m_store_align.sv
// Byte-lane strobe and store-data replication for a 32-bit little-endian bus.
module m_store_align
    import m_mem_access_pkg::*;
(
    input  logic [3:0]  i_ls_op,
    input  logic [1:0]  i_addr_low2,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byteen,
    output logic [31:0] o_wdata
);

    // Loads read the whole word; stores replicate their data into every lane
    // so the strobes alone select which bytes land in memory.
    always_comb begin
        o_byteen = 4'b0000;
        o_wdata  = 32'h0;
        case (i_ls_op)
            LS_LW, LS_LH, LS_LHU, LS_LB, LS_LBU: begin
                o_byteen = 4'b1111;
            end
            LS_SW: begin
                o_byteen = 4'b1111;
                o_wdata  = i_wdata;
            end
            LS_SH: begin
                o_byteen = i_addr_low2[1] ? 4'b1100 : 4'b0011;
                o_wdata  = {2{i_wdata[15:0]}};
            end
            LS_SB: begin
                o_byteen = 4'b0001 << i_addr_low2;
                o_wdata  = {4{i_wdata[7:0]}};
            end
            default: begin
                o_byteen = 4'b0000;
                o_wdata  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/m_mem_access.sv
// M-stage memory access: launches one bus transaction per load/store, stalls
// the pipeline until the bus acknowledges, then pulses done for one cycle.
module m_mem_access
    import m_mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  lsOp_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    input  logic        flush,
    output logic        stall_M,
    output logic        exc_AdEL,
    output logic        exc_AdES,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic        m_req,
    output logic        m_wr,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic [31:0] dataOut,
    output logic [3:0]  lsOpOut,
    output logic [1:0]  addrLow2Out,
    output logic        done
);

    mem_state_e  r_state;
    logic        r_kill;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_aligned;
    logic        w_valid;
    logic        w_idle;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;

    assign w_is_load  = is_load(lsOp_M);
    assign w_is_store = is_store(lsOp_M);
    assign w_aligned  = is_aligned(lsOp_M, addr_M[1:0]);
    assign w_valid    = (w_is_load || w_is_store) && w_aligned && !flush;
    assign w_idle     = (r_state == ST_IDLE);

    m_store_align u_store_align (
        .i_ls_op     (lsOp_M),
        .i_addr_low2 (addr_M[1:0]),
        .i_wdata     (wdata_M),
        .o_byteen    (w_byteen),
        .o_wdata     (w_wdata)
    );

    // Pipeline hold and address exceptions are decided combinationally so the
    // stall takes effect in the same cycle the instruction reaches M.
    always_comb begin
        stall_M  = (w_idle && w_valid) || (r_state == ST_WAIT);
        exc_AdEL = w_idle && w_is_load  && !w_aligned;
        exc_AdES = w_idle && w_is_store && !w_aligned;
    end

    // Access FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_kill      <= 1'b0;
            m_req       <= 1'b0;
            m_wr        <= 1'b0;
            m_addr      <= 32'h0;
            m_wdata     <= 32'h0;
            m_byteen    <= 4'b0000;
            dataOut     <= 32'h0;
            lsOpOut     <= 4'b0000;
            addrLow2Out <= 2'b00;
            done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done   <= 1'b0;
                    r_kill <= 1'b0;
                    if (w_valid) begin
                        r_state     <= ST_WAIT;
                        m_req       <= 1'b1;
                        m_wr        <= w_is_store;
                        m_addr      <= {addr_M[31:2], 2'b00};
                        m_byteen    <= w_byteen;
                        m_wdata     <= w_wdata;
                        lsOpOut     <= lsOp_M;
                        addrLow2Out <= addr_M[1:0];
                    end
                end
                ST_WAIT: begin
                    // A flush cannot cancel the bus cycle; it only suppresses
                    // the result, including a flush arriving with the ack.
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= ST_DONE;
                        if (!(r_kill || flush)) begin
                            done <= 1'b1;
                            if (is_load(lsOpOut)) begin
                                dataOut <= m_rdata;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_kill  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_access.sv
// Self-checking bench for m_mem_access: directed vector table, randomized
// accesses against a behavioural model, and hand-written reset/flush/ack cases.
module tb_m_mem_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  lsOp_M;
    logic [31:0] addr_M;
    logic [31:0] wdata_M;
    logic        flush;
    logic        stall_M;
    logic        exc_AdEL;
    logic        exc_AdES;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_req;
    logic        m_wr;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [31:0] dataOut;
    logic [3:0]  lsOpOut;
    logic [1:0]  addrLow2Out;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    m_mem_access dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lsOp_M      (lsOp_M),
        .addr_M      (addr_M),
        .wdata_M     (wdata_M),
        .flush       (flush),
        .stall_M     (stall_M),
        .exc_AdEL    (exc_AdEL),
        .exc_AdES    (exc_AdES),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_byteen    (m_byteen),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata),
        .dataOut     (dataOut),
        .lsOpOut     (lsOpOut),
        .addrLow2Out (addrLow2Out),
        .done        (done)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;     // WAIT cycles before the ack cycle
        int          flush_at;  // WAIT cycle index carrying flush, -1 for none
        logic        exc_l;
        logic        exc_s;
        logic [3:0]  byteen;
        logic [31:0] wlane;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes from the opcode (0 = no access).
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic vec_t make_vec(input logic [3:0] op, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [31:0] rdata,
                                      input int waits, input int flush_at);
        vec_t v;
        int   sz;
        int   be;
        bit   mis;
        sz = op_size(op);
        mis = (sz != 0) && ((int'(addr[1:0]) % sz) != 0);
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.flush_at = flush_at;
        v.exc_l = mis && op_is_load(op);
        v.exc_s = mis && !op_is_load(op);
        be = ((1 << sz) - 1) << int'(addr[1:0]);
        if (sz == 0)            v.byteen = 4'h0;
        else if (op_is_load(op) || sz == 4) v.byteen = 4'hF;
        else                    v.byteen = be[3:0];
        if (sz == 0 || op_is_load(op)) v.wlane = 32'h0;
        else if (sz == 4)       v.wlane = wdata;
        else if (sz == 2)       v.wlane = {16'h0, wdata[15:0]} * 32'h0001_0001;
        else                    v.wlane = {24'h0, wdata[7:0]} * 32'h0101_0101;
        return v;
    endfunction

    // Drive one M-stage instruction and check every cycle it spends in M.
    task automatic run_vec(input vec_t v);
        bit launch;
        bit killed;
        launch = (op_size(v.op) != 0) && !v.exc_l && !v.exc_s;
        killed = 0;
        @(posedge clk); #1;
        lsOp_M = v.op; addr_M = v.addr; wdata_M = v.wdata; flush = 0; m_ack = 0;
        @(negedge clk);
        chk("exc_AdEL", 32'(exc_AdEL), 32'(v.exc_l));
        chk("exc_AdES", 32'(exc_AdES), 32'(v.exc_s));
        chk("stall_detect", 32'(stall_M), 32'(launch));
        chk("m_req_idle", 32'(m_req), 32'h0);
        if (!launch) begin
            @(posedge clk); #1;
            lsOp_M = 4'd0;
            @(negedge clk);
            chk("m_req_nolaunch", 32'(m_req), 32'h0);
            chk("done_nolaunch", 32'(done), 32'h0);
            $display("txn op=%h addr=%08h no launch exc_l=%0d exc_s=%0d", v.op, v.addr, v.exc_l, v.exc_s);
            return;
        end
        for (int k = 0; k <= v.waits; k++) begin
            @(posedge clk); #1;
            flush   = (k == v.flush_at);
            m_ack   = (k == v.waits);
            m_rdata = (k == v.waits) ? v.rdata : $urandom;
            if (flush) killed = 1;
            @(negedge clk);
            chk("m_req", 32'(m_req), 32'h1);
            chk("m_wr", 32'(m_wr), 32'(!op_is_load(v.op)));
            chk("m_addr", m_addr, v.addr & 32'hFFFF_FFFC);
            chk("m_byteen", 32'(m_byteen), 32'(v.byteen));
            chk("m_wdata", m_wdata, v.wlane);
            chk("lsOpOut", 32'(lsOpOut), 32'(v.op));
            chk("addrLow2Out", 32'(addrLow2Out), 32'(v.addr[1:0]));
            chk("stall_wait", 32'(stall_M), 32'h1);
            chk("done_wait", 32'(done), 32'h0);
        end
        @(posedge clk); #1;
        m_ack = 0; flush = 0; lsOp_M = 4'd0;
        @(negedge clk);
        if (op_is_load(v.op) && !killed) exp_data = v.rdata;
        chk("done_pulse", 32'(done), 32'(!killed));
        chk("stall_done", 32'(stall_M), 32'h0);
        chk("m_req_done", 32'(m_req), 32'h0);
        chk("dataOut", dataOut, exp_data);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'h0);
        $display("txn op=%h addr=%08h waits=%0d flush_at=%0d killed=%0d dataOut=%08h",
                 v.op, v.addr, v.waits, v.flush_at, killed, dataOut);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        vec_t rv;

        tbl[0] = '{4'd1, 32'h100, 32'h0,        32'hDEADBEEF, 0, -1, 1'b0, 1'b0, 4'b1111, 32'h0};
        tbl[1] = '{4'd8, 32'h203, 32'h000000A5, 32'h0,        3, -1, 1'b0, 1'b0, 4'b1000, 32'hA5A5A5A5};
        tbl[2] = '{4'd2, 32'h101, 32'h0,        32'h0,        0, -1, 1'b1, 1'b0, 4'b0000, 32'h0};
        tbl[3] = '{4'd6, 32'h102, 32'h0,        32'h0,        0, -1, 1'b0, 1'b1, 4'b0000, 32'h0};
        tbl[4] = '{4'd5, 32'h302, 32'h0,        32'h11223344, 2,  0, 1'b0, 1'b0, 4'b1111, 32'h0};
        tbl[5] = '{4'd7, 32'h106, 32'h1234BEEF, 32'h0,        1, -1, 1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF};
        tbl[6] = '{4'd6, 32'h010, 32'hCAFEF00D, 32'h0,        0, -1, 1'b0, 1'b0, 4'b1111, 32'hCAFEF00D};
        tbl[7] = '{4'd4, 32'h007, 32'h0,        32'h55667788, 1, -1, 1'b0, 1'b0, 4'b1111, 32'h0};
        tbl[8] = '{4'hB, 32'h000, 32'h0,        32'h0,        0, -1, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[9] = '{4'd7, 32'h204, 32'h0000ABCD, 32'h0,        0,  0, 1'b0, 1'b0, 4'b0011, 32'hABCDABCD};

        reset_n = 0; lsOp_M = 0; addr_M = 0; wdata_M = 0; flush = 0; m_ack = 0; m_rdata = 0;
        exp_data = 32'h0;
        #12;
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_wr", 32'(m_wr), 32'h0);
        chk("rst_m_byteen", 32'(m_byteen), 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_dataOut", dataOut, 32'h0);
        chk("rst_lsOpOut", 32'(lsOpOut), 32'h0);
        chk("rst_addrLow2Out", 32'(addrLow2Out), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_stall", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        reset_n = 1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Flush in IDLE suppresses the launch.
        @(posedge clk); #1;
        lsOp_M = 4'd1; addr_M = 32'h40; flush = 1;
        @(negedge clk);
        chk("flush_idle_stall", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        lsOp_M = 4'd0; flush = 0;
        @(negedge clk);
        chk("flush_idle_req", 32'(m_req), 32'h0);
        $display("txn flush in IDLE");

        // An ack while IDLE is ignored.
        @(posedge clk); #1;
        m_ack = 1; m_rdata = 32'h99887766;
        @(posedge clk); #1;
        m_ack = 0;
        @(negedge clk);
        chk("stray_ack_done", 32'(done), 32'h0);
        chk("stray_ack_req", 32'(m_req), 32'h0);
        chk("stray_ack_data", dataOut, exp_data);
        $display("txn stray ack in IDLE");

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            int w;
            int fa;
            op = 4'($urandom_range(0, 9));
            w  = $urandom_range(0, 3);
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : -1;
            rv = make_vec(op, $urandom, $urandom, $urandom, w, fa);
            run_vec(rv);
        end

        // Reset mid-WAIT drops the request at once; a late ack is ignored.
        @(posedge clk); #1;
        lsOp_M = 4'd1; addr_M = 32'h80;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midwait_req", 32'(m_req), 32'h1);
        #1 reset_n = 0;
        #1;
        exp_data = 32'h0;
        chk("async_rst_req", 32'(m_req), 32'h0);
        chk("async_rst_data", dataOut, exp_data);
        chk("async_rst_lsop", 32'(lsOpOut), 32'h0);
        @(posedge clk); #1;
        lsOp_M = 4'd0; reset_n = 1;
        @(posedge clk); #1;
        m_ack = 1; m_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_ack_req", 32'(m_req), 32'h0);
        chk("late_ack_stall", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        m_ack = 0;
        @(negedge clk);
        chk("late_ack_done", 32'(done), 32'h0);
        chk("late_ack_data", dataOut, exp_data);
        @(posedge clk); #1;
        @(negedge clk);
        chk("late_ack_done2", 32'(done), 32'h0);
        $display("txn reset mid-WAIT with late ack");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
